// File: rtl/execute_muldiv_pkg.sv
// Shared types for the Execute-stage multiply/divide unit: op and state
// encodings plus the op classifier used by the datapath.
package execute_muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MUL,
    MD_MULH,
    MD_MULHSU,
    MD_MULHU,
    MD_DIV,
    MD_DIVU,
    MD_REM,
    MD_REMU
  } mulDivOp_;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } mulDivState_;

  typedef struct packed {
    logic isHigh;
    logic signedA;
    logic signedB;
    logic isRem;
  } mulDivClass_;

  function automatic mulDivClass_ classifyOp(input mulDivOp_ op);
    mulDivClass_ c;
    c.isHigh  = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    c.signedA = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    c.signedB = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    c.isRem   = (op == MD_REM) || (op == MD_REMU);
    return c;
  endfunction

  function automatic logic isMulOp(input mulDivOp_ op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction

endpackage

// File: rtl/execute_muldiv_mul_pipe.sv
// mul_pipe: XLEN x XLEN multiplier with per-operand signedness and
// MUL_STAGES retiming registers behind the full 2*XLEN product.
module mul_pipe
  import execute_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [XLEN-1:0]     multA,
  input  logic [XLEN-1:0]     multB,
  input  logic                signedA,
  input  logic                signedB,
  output logic [2*XLEN-1:0]   product
);

  logic [2*XLEN-1:0] extA;
  logic [2*XLEN-1:0] extB;
  logic [2*XLEN-1:0] fullProduct;
  logic [2*XLEN-1:0] stageReg [MUL_STAGES];

  // Two's-complement products are exact modulo 2^(2*XLEN) once both
  // operands are extended to the full product width.
  assign extA        = {{XLEN{signedA & multA[XLEN-1]}}, multA};
  assign extB        = {{XLEN{signedB & multB[XLEN-1]}}, multB};
  assign fullProduct = extA * extB;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < MUL_STAGES; i++) stageReg[i] <= '0;
    end else begin
      stageReg[0] <= fullProduct;
      for (int i = 1; i < MUL_STAGES; i++) stageReg[i] <= stageReg[i-1];
    end
  end

  assign product = stageReg[MUL_STAGES-1];

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the Execute stage.
// Define MULDIV_EARLY_OUT_EN to resolve trivial divides in one cycle.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic            start,
  input  mulDivOp_        op,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic            flush,
  output logic            ready,
  output logic            resultValid,
  output logic [XLEN-1:0] result,
  input  logic            resultAccept,
  output mulDivState_     debugState
);

  localparam int CW = $clog2(XLEN + 1);

  mulDivState_       state, stateNext;
  mulDivOp_          opReg, curOp;
  mulDivClass_       cls;
  logic [XLEN-1:0]   aReg, bReg, curA, curB;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   remReg, quoReg, divisorReg;
  logic              accept, mulLast, divLast;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mulResult;
  logic [XLEN-1:0]   magA, magB;
  logic [XLEN:0]     shifted;
  logic              quoBit;
  logic [XLEN-1:0]   remNext, quoNext, divResult;
  logic              negQ, negR;
  logic              earlyDone;
  logic [XLEN-1:0]   earlyResult;

  // Handshake: start is taken only while ready (IDLE); resultValid/result
  // then hold until a cycle with resultAccept=1, and flush overrides both.
  assign accept      = (state == IDLE) && start && (op != MD_NONE) && !flush;
  assign ready       = (state == IDLE);
  assign resultValid = (state == DONE);
  assign debugState  = state;

  // The launch cycle feeds the multiplier straight from the inputs so its
  // first register captures at the accepting edge.
  assign curOp = accept ? op : opReg;
  assign curA  = accept ? operandA : aReg;
  assign curB  = accept ? operandB : bReg;
  assign cls   = classifyOp(curOp);

  mul_pipe #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) uMulPipe (
    .clock   (clock),
    .resetN  (resetN),
    .multA   (curA),
    .multB   (curB),
    .signedA (cls.signedA),
    .signedB (cls.signedB),
    .product (product)
  );

  assign mulResult = cls.isHigh ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
  assign mulLast   = (count == CW'(MUL_STAGES - 1));
  assign divLast   = (count == CW'(XLEN));

  assign magA    = (cls.signedA && aReg[XLEN-1]) ? -aReg : aReg;
  assign magB    = (cls.signedB && bReg[XLEN-1]) ? -bReg : bReg;
  assign shifted = {remReg, quoReg[XLEN-1]};
  assign quoBit  = (shifted >= {1'b0, divisorReg});
  assign remNext = quoBit ? XLEN'(shifted - {1'b0, divisorReg}) : shifted[XLEN-1:0];
  assign quoNext = {quoReg[XLEN-2:0], quoBit};

  // A zero divisor keeps the all-ones quotient regardless of dividend sign.
  assign negQ      = cls.signedA && (aReg[XLEN-1] ^ bReg[XLEN-1]) && (bReg != '0);
  assign negR      = cls.signedA && aReg[XLEN-1];
  assign divResult = cls.isRem ? (negR ? -remNext : remNext)
                               : (negQ ? -quoNext : quoNext);

`ifdef MULDIV_EARLY_OUT_EN
  assign earlyDone   = (magB == '0) || (magA < magB);
  assign earlyResult = cls.isRem ? aReg : {XLEN{magB == '0}};
`else
  assign earlyDone   = 1'b0;
  assign earlyResult = '0;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: if (start && op != MD_NONE) stateNext = isMulOp(op) ? MUL : DIV;
        MUL:  if (mulLast) stateNext = DONE;
        DIV:  if ((count == '0 && earlyDone) || divLast) stateNext = DONE;
        DONE: if (resultAccept) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      opReg      <= MD_NONE;
      aReg       <= '0;
      bReg       <= '0;
      count      <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      result     <= '0;
    end else if (flush) begin
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opReg <= op;
          aReg  <= operandA;
          bReg  <= operandB;
          count <= '0;
        end
        MUL: if (mulLast) begin
          result <= mulResult;
          count  <= '0;
        end else begin
          count <= count + CW'(1);
        end
        // count 0 is the operand-prep cycle; counts 1..XLEN each retire one quotient bit.
        DIV: if (count == '0) begin
          remReg     <= '0;
          quoReg     <= magA;
          divisorReg <= magB;
          count      <= CW'(1);
          if (earlyDone) begin
            result <= earlyResult;
            count  <= '0;
          end
        end else begin
          remReg <= remNext;
          quoReg <= quoNext;
          if (divLast) begin
            result <= divResult;
            count  <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: if (resultAccept) result <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed plus randomised bench for execute_muldiv (XLEN=32, MUL_STAGES=2),
// checking values, latencies, hold/accept, flush and asynchronous reset.
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  mulDivOp_    op = MD_NONE;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        flush = 1'b0;
  logic        ready;
  logic        resultValid;
  logic [31:0] result;
  logic        resultAccept = 1'b0;
  mulDivState_ debugState;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];

  execute_muldiv #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clock        (clock),
    .resetN       (resetN),
    .start        (start),
    .op           (op),
    .operandA     (operandA),
    .operandB     (operandB),
    .flush        (flush),
    .ready        (ready),
    .resultValid  (resultValid),
    .result       (result),
    .resultAccept (resultAccept),
    .debugState   (debugState)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one op, wait for its result, compare against the scoreboard,
  // optionally hold it unaccepted for holdCycles, then accept it.
  task automatic runOp(input mulDivOp_ o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat, input int holdCycles,
                       input string tag);
    int lat;
    logic [31:0] expVal;
    expQ.push_back(expRes);
    @(negedge clock);
    check({tag, " ready before start"}, 32'(ready), 32'd1);
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(posedge clock); #1;
    start = 1'b0; op = MD_NONE;
    operandA = $urandom; operandB = $urandom;
    lat = 0;
    while (!resultValid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    expVal = expQ.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(expLat));
    check({tag, " result"}, result, expVal);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clock);
      start = (i == 0); op = MD_DIV;
      @(posedge clock); #1;
      start = 1'b0; op = MD_NONE;
      check({tag, " held valid"}, 32'(resultValid), 32'd1);
      check({tag, " held result"}, result, expVal);
    end
    @(negedge clock); resultAccept = 1'b1;
    @(posedge clock); #1; resultAccept = 1'b0;
    check({tag, " valid after accept"}, 32'(resultValid), 32'd0);
    check({tag, " result after accept"}, result, 32'd0);
  endtask

  initial begin
    int sawValid;
    logic [31:0] ra, rb;
    logic [63:0] p;

    repeat (3) @(posedge clock);
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset valid", 32'(resultValid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset state", 32'(debugState), 32'(IDLE));
    @(negedge clock); resetN = 1'b1;

    runOp(MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0, "mul 7*-3");
    runOp(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0, "mulh");
    runOp(MD_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0, "mulhu");
    runOp(MD_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MUL_LAT, 0, "mulhsu");
    runOp(MD_DIV,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, DIV_LAT, 0, "div -20/3");
    runOp(MD_REM,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, DIV_LAT, 0, "rem -20/3");
    runOp(MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, ZERO_LAT, 0, "divu 5/0");
    runOp(MD_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, ZERO_LAT, 0, "div -7/0");
    runOp(MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, ZERO_LAT, 0, "rem -7/0");
    runOp(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT, 0, "rem ovf");
    runOp(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT, 0, "div ovf");

    // start with MD_NONE must be ignored
    @(negedge clock); start = 1'b1; op = MD_NONE;
    @(posedge clock); #1; start = 1'b0;
    check("none ready", 32'(ready), 32'd1);
    check("none state", 32'(debugState), 32'(IDLE));

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      p = {32'd0, ra} * {32'd0, rb};
      runOp(MD_MUL, ra, rb, p[31:0], MUL_LAT, 0, "rand mul");
      runOp(MD_MULHU, ra, rb, p[63:32], MUL_LAT, 0, "rand mulhu");
      ra = $urandom_range(32'hFFFF_FFFF, 32'h1000_0000);
      rb = $urandom_range(32'h0FFF_FFFF, 1);
      runOp(MD_DIVU, ra, rb, ra / rb, DIV_LAT, 0, "rand divu");
      runOp(MD_REMU, ra, rb, ra % rb, DIV_LAT, 0, "rand remu");
    end

    // flush mid-divide discards the operation
    @(negedge clock); start = 1'b1; op = MD_DIV; operandA = 32'd100; operandB = 32'd7;
    @(posedge clock); #1; start = 1'b0; op = MD_NONE;
    repeat (10) @(posedge clock);
    @(negedge clock); flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    check("flush ready", 32'(ready), 32'd1);
    check("flush valid", 32'(resultValid), 32'd0);
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (resultValid) sawValid++;
    end
    check("flush no result", 32'(sawValid), 32'd0);
    runOp(MD_MUL, 32'd12345, 32'd678, 32'd8369910, MUL_LAT, 0, "mul after flush");

    // result held unaccepted for 5 cycles, start during DONE ignored
    runOp(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, 5, "mul hold");

    // asynchronous reset in the middle of a divide
    @(negedge clock); start = 1'b1; op = MD_DIV; operandA = 32'd1000; operandB = 32'd3;
    @(posedge clock); #1; start = 1'b0; op = MD_NONE;
    repeat (5) @(posedge clock);
    #2; resetN = 1'b0;
    #1;
    check("async reset ready", 32'(ready), 32'd1);
    check("async reset valid", 32'(resultValid), 32'd0);
    check("async reset result", result, 32'd0);
    check("async reset state", 32'(debugState), 32'(IDLE));
    @(negedge clock); resetN = 1'b1;
    runOp(MD_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT, 0, "divu after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
